// File: rtl/ram_256x8.sv
// Single-port synchronous RAM, 256 x 8, with a shared address bus, separate read/write
// strobes gated by a chip enable, and a registered read port that holds between reads.
module ram_256x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  input  logic              r,
  input  logic              w,
  input  logic              en
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is built from resettable flops so an asynchronous reset clears every word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (en && w) begin
      mem[addr] <= in;
    end
  end

  // Read register: a combined read/write returns the incoming data (write-through).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else if (en && r) begin
      out <= w ? in : mem[addr];
    end
  end

endmodule

// File: tb/tb_ram_256x8.sv
// Directed bench for ram_256x8: reset, disabled access, write/read, write-through,
// hold/isolation, back-to-back access and asynchronous reset mid-run.
module tb_ram_256x8;

  logic       clk;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] in;
  logic [7:0] out;
  logic       r;
  logic       w;
  logic       en;

  int tests;
  int fails;

  ram_256x8 dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .in   (in),
    .out  (out),
    .r    (r),
    .w    (w),
    .en   (en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; r = 1'b0; w = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    en = 1'b1; w = 1'b1; r = 1'b0; addr = a; in = d;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [7:0] a, output logic [7:0] d);
    en = 1'b1; r = 1'b1; w = 1'b0; addr = a;
    tick();
    d = out;
    idle();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    idle(); addr = 8'h00; in = 8'h00;
    rst = 1'b1;
    #3;
    tests++;
    if (out !== 8'h00) begin
      fails++; $display("FAIL reset_out_async: got %h required %h", out, 8'h00);
    end
    tick(); tick();
    tests++;
    if (out !== 8'h00) begin
      fails++; $display("FAIL reset_out_held: got %h required %h", out, 8'h00);
    end
    rst = 1'b0;
    do_read(8'h00, d);
    tests++;
    if (d !== 8'h00) begin
      fails++; $display("FAIL reset_read_00: got %h required %h", d, 8'h00);
    end
    do_read(8'hFF, d);
    tests++;
    if (d !== 8'h00) begin
      fails++; $display("FAIL reset_read_ff: got %h required %h", d, 8'h00);
    end
  endtask

  task automatic test_disabled();
    logic [7:0] d;
    en = 1'b0; w = 1'b1; r = 1'b1; addr = 8'h88; in = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (out !== 8'h00) begin
        fails++; $display("FAIL disabled_out_cycle%0d: got %h required %h", i, out, 8'h00);
      end
    end
    idle();
    do_read(8'h88, d);
    tests++;
    if (d !== 8'h00) begin
      fails++; $display("FAIL disabled_no_write: got %h required %h", d, 8'h00);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] d;
    do_write(8'h88, 8'hFF);
    tests++;
    if (out !== 8'h00) begin
      fails++; $display("FAIL write_only_out_holds: got %h required %h", out, 8'h00);
    end
    do_read(8'h88, d);
    tests++;
    if (d !== 8'hFF) begin
      fails++; $display("FAIL write_read_88: got %h required %h", d, 8'hFF);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] d;
    en = 1'b1; r = 1'b1; w = 1'b1; addr = 8'h10; in = 8'h5A;
    tick();
    idle();
    tests++;
    if (out !== 8'h5A) begin
      fails++; $display("FAIL rw_write_through: got %h required %h", out, 8'h5A);
    end
    do_read(8'h88, d);
    tests++;
    if (d !== 8'hFF) begin
      fails++; $display("FAIL rw_other_word: got %h required %h", d, 8'hFF);
    end
    do_read(8'h10, d);
    tests++;
    if (d !== 8'h5A) begin
      fails++; $display("FAIL rw_readback_10: got %h required %h", d, 8'h5A);
    end
  endtask

  task automatic test_hold();
    logic [7:0] d;
    do_write(8'h01, 8'h11);
    do_write(8'h02, 8'h22);
    do_read(8'h01, d);
    tests++;
    if (d !== 8'h11) begin
      fails++; $display("FAIL hold_read_01: got %h required %h", d, 8'h11);
    end
    en = 1'b0; r = 1'b1; w = 1'b1; addr = 8'h02; in = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (out !== 8'h11) begin
        fails++; $display("FAIL hold_en0_cycle%0d: got %h required %h", i, out, 8'h11);
      end
    end
    en = 1'b1; r = 1'b0; w = 1'b0;
    tick();
    tests++;
    if (out !== 8'h11) begin
      fails++; $display("FAIL hold_no_strobe: got %h required %h", out, 8'h11);
    end
    idle();
    do_read(8'h02, d);
    tests++;
    if (d !== 8'h22) begin
      fails++; $display("FAIL hold_read_02: got %h required %h", d, 8'h22);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_a [4];
    logic [7:0] exp_d [4];
    exp_a[0] = 8'h20; exp_d[0] = 8'hA1;
    exp_a[1] = 8'h21; exp_d[1] = 8'hB2;
    exp_a[2] = 8'hFF; exp_d[2] = 8'hC3;
    exp_a[3] = 8'h00; exp_d[3] = 8'h3C;
    en = 1'b1; w = 1'b1; r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = exp_a[i]; in = exp_d[i];
      tick();
    end
    w = 1'b0; r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = exp_a[i];
      tick();
      tests++;
      if (out !== exp_d[i]) begin
        fails++; $display("FAIL b2b_read_%h: got %h required %h", exp_a[i], out, exp_d[i]);
      end
    end
    addr = 8'h01;
    tick();
    tests++;
    if (out !== 8'h11) begin
      fails++; $display("FAIL b2b_read_01_isolated: got %h required %h", out, 8'h11);
    end
    idle();
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    en = 1'b1; w = 1'b1; r = 1'b0; addr = 8'h30; in = 8'h77;
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (out !== 8'h00) begin
      fails++; $display("FAIL async_reset_out: got %h required %h", out, 8'h00);
    end
    tick();
    rst = 1'b0;
    idle();
    do_read(8'h01, d);
    tests++;
    if (d !== 8'h00) begin
      fails++; $display("FAIL async_reset_read_01: got %h required %h", d, 8'h00);
    end
    do_read(8'h88, d);
    tests++;
    if (d !== 8'h00) begin
      fails++; $display("FAIL async_reset_read_88: got %h required %h", d, 8'h00);
    end
    do_read(8'h30, d);
    tests++;
    if (d !== 8'h00) begin
      fails++; $display("FAIL async_reset_pending_write: got %h required %h", d, 8'h00);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0; addr = 8'h00; in = 8'h00;
    idle();
    test_reset();
    test_disabled();
    test_write_read();
    test_simultaneous();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
